l2_miss_responder: RTL

// - L2-side responder for one core's L1 load miss queue. Accepts miss requests over the dequeue handshake.
// - Buffers them in order, issues cache-line reads to the memory/L2 backing port, then returns
//   l2_response_valid/idx/data/sync to the originating L1 miss-queue entry.
// - Sits between a core's L1 miss queue and the L2/memory read interface.

---
 rtl/l2_miss_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/l2_miss_responder.sv
`default_nettype none
//==============================================================================
// Module   : l2_miss_responder
// Brief    : In-order buffer of L1 load misses. It issues line reads to the
//            backing port and returns tagged responses to the L1 miss entries.
// Revision : 1.0 - initial release
//==============================================================================
module l2_miss_responder #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int IDX_WIDTH  = 2,
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_ready,
    output logic                  miss_ack,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic [IDX_WIDTH-1:0]  miss_idx,
    input  logic                  miss_sync,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  l2_response_valid,
    output logic [IDX_WIDTH-1:0]  l2_response_idx,
    output logic [DATA_WIDTH-1:0] l2_response_data,
    output logic                  l2_response_sync
);

    localparam int                 c_SLOT_W  = $clog2(DEPTH);
    localparam int                 c_PTR_W   = c_SLOT_W + 1;
    localparam logic [c_PTR_W-1:0] c_DEPTH   = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [c_PTR_W-1:0]    r_alloc_ptr;
    logic [c_PTR_W-1:0]    r_issue_ptr;
    logic [c_PTR_W-1:0]    r_retire_ptr;
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [IDX_WIDTH-1:0]  r_idx  [DEPTH];
    logic                  r_sync [DEPTH];

    logic [c_PTR_W-1:0]    w_count;
    logic                  w_full;
    logic                  w_ack;
    logic                  w_issue;

    // No retire bypass: occupancy comes from the registered pointers alone.
    assign w_count       = r_alloc_ptr - r_retire_ptr;
    assign w_full        = (w_count == c_DEPTH);
    assign w_ack         = miss_ready && !w_full && !reset;
    assign miss_ack      = w_ack;
    assign mem_req_valid = (r_issue_ptr != r_alloc_ptr);
    assign mem_req_addr  = r_addr[r_issue_ptr[c_SLOT_W-1:0]];
    assign w_issue       = mem_req_valid && mem_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alloc_ptr  <= '0;
            r_issue_ptr  <= '0;
            r_retire_ptr <= '0;
        end else begin
            if (w_ack)          r_alloc_ptr  <= r_alloc_ptr + c_PTR_ONE;
            if (w_issue)        r_issue_ptr  <= r_issue_ptr + c_PTR_ONE;
            if (mem_resp_valid) r_retire_ptr <= r_retire_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ack) begin
            r_addr[r_alloc_ptr[c_SLOT_W-1:0]] <= miss_addr;
            r_idx[r_alloc_ptr[c_SLOT_W-1:0]]  <= miss_idx;
            r_sync[r_alloc_ptr[c_SLOT_W-1:0]] <= miss_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2_response_valid <= 1'b0;
            l2_response_idx   <= '0;
            l2_response_sync  <= 1'b0;
            l2_response_data  <= '0;
        end else begin
            l2_response_valid <= mem_resp_valid;
            if (mem_resp_valid) begin
                l2_response_idx  <= r_idx[r_retire_ptr[c_SLOT_W-1:0]];
                l2_response_sync <= r_sync[r_retire_ptr[c_SLOT_W-1:0]];
                l2_response_data <= mem_resp_data;
            end
        end
    end

`ifndef SYNTHESIS
    logic [DEPTH-1:0]      w_slot_hit;
    logic                  r_stall_prev;
    logic [ADDR_WIDTH-1:0] r_stall_addr;

    // A slot is live when its distance from the retire pointer is below the occupancy.
    for (genvar j = 0; j < DEPTH; j++) begin : g_slot
        logic [c_SLOT_W-1:0] w_off;
        assign w_off         = c_SLOT_W'(j) - r_retire_ptr[c_SLOT_W-1:0];
        assign w_slot_hit[j] = ({1'b0, w_off} < w_count) && (r_idx[j] == miss_idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_prev <= 1'b0;
            r_stall_addr <= '0;
        end else begin
            r_stall_prev <= mem_req_valid && !mem_req_ready;
            r_stall_addr <= mem_req_addr;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!mem_resp_valid || (r_retire_ptr != r_issue_ptr))
                else $error("l2_miss_responder: mem_resp_valid with no issued entry");
            assert (!w_ack || (w_slot_hit == '0))
                else $error("l2_miss_responder: miss_idx %0d already outstanding", miss_idx);
            assert (!r_stall_prev || (mem_req_valid && (mem_req_addr == r_stall_addr)))
                else $error("l2_miss_responder: mem_req changed while stalled");
        end
    end
`endif

endmodule
`default_nettype wire
